aes_sbox_main: RTL and testbench
================================

// Module: aes_sbox_main
// PURPOSE
// - Byte-wide AES S-box datapath with a 4-bit control MUX that selects the next value of an internal state register.
// - Loads a byte, applies the forward (optionally inverse) AES S-box in place, and publishes the state on a registered output.
// - Top-level DUT of the S-box experiment. It has one clock domain and no handshake; all control comes from start[3:0].
// PARAMETERS
// - none (the datapath is fixed at 8 bits)
// PORTS
// - clk        input   1  system clock; every register updates on the rising edge
// - rst        input   1  asynchronous, active-high reset
// - value_in   input   8  byte to load into the state register
// - start      input   4  control vector; see BEHAVIOUR
// - value_out  output  8  registered output byte
// BEHAVIOUR
// - Interface: one clock (clk); reset rst is asynchronous and active-high.
// - Registers: state[7:0] and value_out[7:0].
//   - Asserting rst clears both to 8'h00 immediately, without waiting for a clock edge.
//   - Reset asserted mid-operation aborts that operation. Nothing is retained.
// - State register next value, fixed priority, evaluated at each rising clk edge with rst low:
//   - start[0]=1 -> state <= value_in (load)
//   - else start[1]=1 -> state <= SBOX(state) (forward AES SubBytes)
//   - else start[2]=1 -> state <= INV_SBOX(state) (only when SBOX_INV_EN is defined)
//   - else -> state holds
// - Output register, independent of the state priority:
//   - start[3]=1 -> value_out <= state, using the state value before this edge's update
//   - start[3]=0 -> value_out holds
// - Simultaneous bits resolve by the priority above.
//   - Example: start=4'b0011 loads and does not apply the S-box.
//   - start[3] combined with any other bit captures the old state while state updates.
// - start=4'b0000 is idle: nothing changes, and value_out stays 8'h00 after reset.
// - Latency: load at edge N, S-box at edge N+1, capture at edge N+2; value_out is valid after edge N+2.
//   One S-box application per cycle.
// - SBOX(x): multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1 (0 maps to 0), followed by the AES affine transform with constant 8'h63.
//   - Implement the inverse combinationally, either as a composite-field GF((2^4)^2) tower or as a 256-entry constant case.
//   - It must match FIPS-197 bit-exactly.
// - INV_SBOX(x): inverse affine transform (constant 8'h05), then the same GF(2^8) inversion.
//   Share the inversion logic with SBOX.
// - All datapath logic between registers is purely combinational. No X may propagate out of reset.
// CONFIGURATION
// - SBOX_INV_EN defined: the inverse S-box path exists and start[2] selects it as described.
// - SBOX_INV_EN undefined: the inverse path is not built and start[2] is ignored.
//   - start=4'b0100 then behaves as idle (state holds).
//   - All other behaviour is identical.
// TESTING
// - Reset: rst=1 for 100 ns, value_in=8'h25, start=4'b0000, then rst=0 and keep start=0
//   -> value_out stays 8'h00 indefinitely.
// - Forward: load 8'h25 (start=0001), then start=0010 for one cycle, then start=1000
//   -> value_out=8'h3F; likewise load 8'h00 -> 8'h63 and load 8'h53 -> 8'hED.
// - Priority: start=0011 with value_in=8'hAA, then start=1000 -> value_out=8'hAA (load wins, no S-box applied).
// - Inverse (SBOX_INV_EN): load 8'h3F, start=0100, start=1000 -> value_out=8'h25.
//   Without the macro the same sequence gives 8'h3F.
// - Async reset mid-run: after loading 8'h25 and capturing it (value_out=8'h25), pulse rst between clock edges
//   -> value_out=8'h00 and state=8'h00 immediately; a later start=1000 still yields 8'h00.
// - Exhaustive: for all 256 x, load x, apply start=0010, capture -> value_out equals the FIPS-197 S-box table.
//   With SBOX_INV_EN, apply 0010 then 0100 -> value_out equals x.

Source files
------------

// File: rtl/aes_sbox_main_if.sv
// Byte bus of the AES S-box datapath: load byte, control vector, output byte.
// Plain signal bundle, no handshake; the master drives value_in/start.
interface aes_sbox_main_if;
    logic [7:0] value_in;
    logic [3:0] start;
    logic [7:0] value_out;

    modport master (
        output value_in,
        output start,
        input  value_out
    );

    modport slave (
        input  value_in,
        input  start,
        output value_out
    );
endinterface

// File: rtl/aes_sbox_main.sv
// Byte-wide AES S-box datapath with a priority control MUX on the state register.
// Optional inverse S-box path enabled by defining SBOX_INV_EN.
module aes_sbox_main (
    input  logic             clk,
    input  logic             rst,
    aes_sbox_main_if.slave   bus
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8); 0 maps to 0 for free.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15;
        logic [7:0] x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] a);
        return a
             ^ {a[6:0], a[7]}
             ^ {a[5:0], a[7:6]}
             ^ {a[4:0], a[7:5]}
             ^ {a[3:0], a[7:4]}
             ^ 8'h63;
    endfunction

    logic [7:0] state;
    logic [7:0] state_d;
    logic [7:0] value_q;
    logic [7:0] inv_in;
    logic [7:0] inv_out;
    logic [7:0] sbox_out;

`ifdef SBOX_INV_EN
    function automatic logic [7:0] inv_affine(input logic [7:0] a);
        return {a[6:0], a[7]}
             ^ {a[4:0], a[7:5]}
             ^ {a[1:0], a[7:2]}
             ^ 8'h05;
    endfunction

    // One inverter serves both directions; forward wins when both are asked.
    always_comb begin
        inv_in = bus.start[1] ? state : inv_affine(state);
    end
`else
    logic unused_start2;
    assign unused_start2 = bus.start[2];

    always_comb begin
        inv_in = state;
    end
`endif

    always_comb begin
        inv_out  = gf_inv(inv_in);
        sbox_out = fwd_affine(inv_out);
    end

    always_comb begin
        state_d = state;
        if (bus.start[0]) begin
            state_d = bus.value_in;
        end else if (bus.start[1]) begin
            state_d = sbox_out;
`ifdef SBOX_INV_EN
        end else if (bus.start[2]) begin
            state_d = inv_out;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= 8'h00;
            value_q <= 8'h00;
        end else begin
            state <= state_d;
            if (bus.start[3]) value_q <= state;
        end
    end

    assign bus.value_out = value_q;

endmodule

// File: tb/tb_aes_sbox_main.sv
// Scoreboard bench for aes_sbox_main: directed vectors plus full S-box sweep.
// Expected bytes come from the FIPS-197 table held locally.
module tb_aes_sbox_main;

    logic clk;
    logic rst;
    aes_sbox_main_if ifc ();

    aes_sbox_main dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q [$];

    logic [7:0] sbox_tab [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; a capture queues the byte it should publish.
    task automatic cyc(input logic [3:0] s, input logic [7:0] v,
                       input logic [7:0] exp);
        @(negedge clk);
        ifc.start    = s;
        ifc.value_in = v;
        if (s[3]) exp_q.push_back(exp);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!rst && ifc.start[3]) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL cap: got %h, want none queued", ifc.value_out);
                end else begin
                    check("cap", ifc.value_out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] inv_exp;
        rst          = 1'b1;
        ifc.value_in = 8'h25;
        ifc.start    = 4'b0000;
        #100;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_idle", ifc.value_out, 8'h00);
        end

        cyc(4'b0001, 8'h25, 8'h00);
        cyc(4'b0010, 8'h00, 8'h00);
        cyc(4'b1000, 8'h00, 8'h3f);
        cyc(4'b0001, 8'h00, 8'h00);
        cyc(4'b0010, 8'h00, 8'h00);
        cyc(4'b1000, 8'h00, 8'h63);
        cyc(4'b0001, 8'h53, 8'h00);
        cyc(4'b0010, 8'h00, 8'h00);
        cyc(4'b1000, 8'h00, 8'hed);

        cyc(4'b0011, 8'haa, 8'h00);
        cyc(4'b1000, 8'h00, 8'haa);
        cyc(4'b1001, 8'h11, 8'haa);
        cyc(4'b1010, 8'h00, 8'h11);
        cyc(4'b1000, 8'h00, sbox_tab[8'h11]);

`ifdef SBOX_INV_EN
        inv_exp = 8'h25;
`else
        inv_exp = 8'h3f;
`endif
        cyc(4'b0001, 8'h3f, 8'h00);
        cyc(4'b0100, 8'h00, 8'h00);
        cyc(4'b1000, 8'h00, inv_exp);

        cyc(4'b0001, 8'h25, 8'h00);
        cyc(4'b1000, 8'h00, 8'h25);
        cyc(4'b0000, 8'h00, 8'h00);
        @(negedge clk);
        check("pre_rst", ifc.value_out, 8'h25);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_out", ifc.value_out, 8'h00);
        check("async_state", dut.state, 8'h00);
        #1 rst = 1'b0;
        cyc(4'b1000, 8'h00, 8'h00);

        for (int x = 0; x < 256; x++) begin
            cyc(4'b0001, 8'(x), 8'h00);
            cyc(4'b0010, 8'h00, 8'h00);
            cyc(4'b1000, 8'h00, sbox_tab[x]);
`ifdef SBOX_INV_EN
            cyc(4'b0001, 8'(x), 8'h00);
            cyc(4'b0010, 8'h00, 8'h00);
            cyc(4'b0100, 8'h00, 8'h00);
            cyc(4'b1000, 8'h00, 8'(x));
`endif
        end

        cyc(4'b0000, 8'h00, 8'h00);
        cyc(4'b0000, 8'h00, 8'h00);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
